// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing constants for the VGA path (default 640x480@60).
// Also provides the per-axis total helper used by the timing decoders.
package vga_sync_gen_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;
  localparam int unsigned CNT_W_DEF     = 10;

  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_timing.sv
// One raster axis: wrapping position counter with registered active/sync decode.
// Decodes are taken from the next position so they never lag o_pos.
module vga_axis_timing
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned FRONT   = H_FRONT_DEF,
  parameter int unsigned SYNC    = H_SYNC_DEF,
  parameter int unsigned BACK    = H_BACK_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_pos,
  output logic             o_active,
  output logic             o_sync,
  output logic             o_wrap
);

  localparam int unsigned      TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FRONT + SYNC - 1);

  logic [CNT_W-1:0] pos_q, pos_d;
  logic             active_q, active_d;
  logic             sync_q, sync_d;
  logic             wrap;

  // High on the last position: the next advance returns to zero.
  assign wrap = (pos_q == LAST);

  always_comb begin
    pos_d = pos_q;
    if (i_adv) begin
      pos_d = wrap ? '0 : pos_q + CNT_W'(1);
    end
    active_d = (pos_d < VIS_END);
    sync_d   = (pos_d >= SYNC_LO) && (pos_d <= SYNC_HI);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q    <= LAST;
      active_q <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign o_pos    = pos_q;
  assign o_active = active_q;
  assign o_sync   = sync_q;
  assign o_wrap   = wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: H/V counters, syncs, visible flag and start strobes.
// Outputs change one clock after an i_pix_en sample; strobes last one clock.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_en,
  output logic [CNT_W-1:0] o_hpos,
  output logic [CNT_W-1:0] o_vpos,
  output logic             o_visible,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_line_start,
  output logic             o_frame_start
);

  logic h_wrap, v_wrap;
  logic h_active, v_active;
  logic h_sync, v_sync;
  logic v_adv;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Lines advance on the same enable that wraps the pixel counter.
  assign v_adv = i_pix_en & h_wrap;

  vga_axis_timing #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
  ) u_h (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_adv   (i_pix_en),
    .o_pos   (o_hpos),
    .o_active(h_active),
    .o_sync  (h_sync),
    .o_wrap  (h_wrap)
  );

  vga_axis_timing #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
  ) u_v (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_adv   (v_adv),
    .o_pos   (o_vpos),
    .o_active(v_active),
    .o_sync  (v_sync),
    .o_wrap  (v_wrap)
  );

  always_comb begin
    line_start_d  = i_pix_en & h_wrap;
    frame_start_d = i_pix_en & h_wrap & v_wrap;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_visible     = h_active & v_active;
  assign o_hsync       = SYNC_POL ? h_sync : ~h_sync;
  assign o_vsync       = SYNC_POL ? v_sync : ~v_sync;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a tiny-raster instance
// sharing clock, reset and enable, both checked against a linear-index model.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;
  always #5 clk = ~clk;

  logic [9:0] a_hpos, a_vpos;
  logic       a_visible, a_hsync, a_vsync, a_line_start, a_frame_start;
  logic [3:0] b_hpos, b_vpos;
  logic       b_visible, b_hsync, b_vsync, b_line_start, b_frame_start;

  vga_sync_gen u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
    .o_hpos(a_hpos), .o_vpos(a_vpos), .o_visible(a_visible),
    .o_hsync(a_hsync), .o_vsync(a_vsync),
    .o_line_start(a_line_start), .o_frame_start(a_frame_start)
  );

  // Small raster: H 8+2+3+2 = 15, V 4+1+2+2 = 9, active-high syncs.
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b1), .CNT_W(4)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
    .o_hpos(b_hpos), .o_vpos(b_vpos), .o_visible(b_visible),
    .o_hsync(b_hsync), .o_vsync(b_vsync),
    .o_line_start(b_line_start), .o_frame_start(b_frame_start)
  );

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit pol;
  } tim_t;

  typedef struct {
    int hpos, vpos;
    bit vis, hs, vs, ls, fs;
  } exp_t;

  typedef struct {
    bit en;
    int hpos, vpos;
    bit vis, ls, fs;
  } vec_t;

  tim_t   ta, tb;
  int     errors = 0;
  int     checks = 0;
  longint n      = 0;
  bit     stb    = 1'b0;
  vec_t   vecs[6];

  // Position is the number of enables since reset, minus one, taken modulo the frame.
  function automatic exp_t model(tim_t t, longint cnt, bit s);
    exp_t   e;
    int     ht  = t.hv + t.hf + t.hs + t.hb;
    int     vt  = t.vv + t.vf + t.vs + t.vb;
    longint fr  = longint'(ht) * longint'(vt);
    longint idx = (cnt + fr - 1) % fr;
    e.hpos = int'(idx % ht);
    e.vpos = int'(idx / ht);
    e.vis  = (e.hpos < t.hv) && (e.vpos < t.vv);
    e.hs   = ((e.hpos >= t.hv + t.hf) && (e.hpos < t.hv + t.hf + t.hs)) ? t.pol : ~t.pol;
    e.vs   = ((e.vpos >= t.vv + t.vf) && (e.vpos < t.vv + t.vf + t.vs)) ? t.pol : ~t.pol;
    e.ls   = s && (e.hpos == 0);
    e.fs   = s && (idx == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    exp_t ea, eb;
    ea = model(ta, n, stb);
    eb = model(tb, n, stb);
    chk("a_hpos", a_hpos, ea.hpos);       chk("a_vpos", a_vpos, ea.vpos);
    chk("a_visible", a_visible, ea.vis);  chk("a_hsync", a_hsync, ea.hs);
    chk("a_vsync", a_vsync, ea.vs);       chk("a_line_start", a_line_start, ea.ls);
    chk("a_frame_start", a_frame_start, ea.fs);
    chk("b_hpos", b_hpos, eb.hpos);       chk("b_vpos", b_vpos, eb.vpos);
    chk("b_visible", b_visible, eb.vis);  chk("b_hsync", b_hsync, eb.hs);
    chk("b_vsync", b_vsync, eb.vs);       chk("b_line_start", b_line_start, eb.ls);
    chk("b_frame_start", b_frame_start, eb.fs);
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    if (en) n++;
    stb = en;
    #1;
  endtask

  task automatic check_reset_consts(input string tag);
    chk({tag, "_a_hpos"}, a_hpos, 799);   chk({tag, "_a_vpos"}, a_vpos, 524);
    chk({tag, "_a_visible"}, a_visible, 0);
    chk({tag, "_a_hsync"}, a_hsync, 1);   chk({tag, "_a_vsync"}, a_vsync, 1);
    chk({tag, "_a_ls"}, a_line_start, 0); chk({tag, "_a_fs"}, a_frame_start, 0);
    chk({tag, "_b_hpos"}, b_hpos, 14);    chk({tag, "_b_vpos"}, b_vpos, 8);
    chk({tag, "_b_hsync"}, b_hsync, 0);   chk({tag, "_b_vsync"}, b_vsync, 0);
  endtask

  // which=0: stop on A hpos == h; which=1: stop on B at (h,v).
  task automatic run_until(input bit which, input int h, input int v);
    int g = 0;
    bit hit;
    hit = which ? (b_hpos == h[3:0] && b_vpos == v[3:0]) : (a_hpos == h[9:0]);
    while (!hit && g < 2000) begin
      step(1'b1);
      check_models();
      g++;
      hit = which ? (b_hpos == h[3:0] && b_vpos == v[3:0]) : (a_hpos == h[9:0]);
    end
    chk("run_until_reached", hit, 1);
  endtask

  task automatic measure(input int every, input int frames);
    int cyc = 0, last_fs = -1, last_ls = -1, nfs = 0, vis_ls = 0, g = 0;
    while (nfs < frames + 1 && g < 5000) begin
      step((cyc % every) == 0);
      cyc++;
      g++;
      check_models();
      if (b_frame_start) begin
        if (last_fs >= 0) begin
          chk("frame_period", cyc - last_fs, every * 135);
          chk("visible_lines", vis_ls, 4);
        end
        last_fs = cyc;
        vis_ls  = 0;
        nfs++;
      end
      if (b_line_start) begin
        if (last_ls >= 0) chk("line_period", cyc - last_ls, every * 15);
        last_ls = cyc;
        if (b_visible) vis_ls++;
      end
    end
    chk("measure_done", nfs >= frames + 1, 1);
  endtask

  initial begin
    ta = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    tb = '{8, 2, 3, 2, 4, 1, 2, 2, 1'b1};
    vecs[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 2, 0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3, 0, 1'b1, 1'b0, 1'b0};

    rst_n  = 1'b1;
    pix_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_consts("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    stb = 1'b0;
    check_models();

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].en);
      chk("vec_hpos", a_hpos, vecs[i].hpos);
      chk("vec_vpos", a_vpos, vecs[i].vpos);
      chk("vec_visible", a_visible, vecs[i].vis);
      chk("vec_line_start", a_line_start, vecs[i].ls);
      chk("vec_frame_start", a_frame_start, vecs[i].fs);
      check_models();
    end

    run_until(1'b0, 655, 0);
    chk("hsync_655", a_hsync, 1);
    step(1'b1); chk("hsync_656", a_hsync, 0);
    run_until(1'b0, 751, 0);
    chk("hsync_751", a_hsync, 0);
    step(1'b1); chk("hsync_752", a_hsync, 1);

    measure(1, 3);
    measure(4, 2);

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)));
      check_models();
    end

    run_until(1'b1, 14, 4);
    step(1'b1);
    chk("vwrap_b_hpos", b_hpos, 0); chk("vwrap_b_vpos", b_vpos, 5);
    chk("vwrap_b_vsync", b_vsync, 1);
    run_until(1'b1, 14, 8);
    step(1'b1);
    chk("fwrap_b_hpos", b_hpos, 0); chk("fwrap_b_vpos", b_vpos, 0);
    chk("fwrap_b_vsync", b_vsync, 0); chk("fwrap_b_fs", b_frame_start, 1);
    check_models();

    run_until(1'b1, 7, 2);
    pix_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_consts("async_rst");
    n = 0;
    stb = 1'b0;
    #1 rst_n = 1'b1;
    step(1'b1);
    chk("post_rst_a_fs", a_frame_start, 1);
    chk("post_rst_b_fs", b_frame_start, 1);
    chk("post_rst_a_hpos", a_hpos, 0);
    check_models();
    step(1'b0);
    chk("post_rst_fs_drop", a_frame_start, 0);
    check_models();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
